muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M/RV64M multiply/divide execution unit for the CPU datapath; sits beside the ALU.
//   Accepts one M-extension op via valid/ready, computes over XLEN/UNROLL cycles, returns result + rd tag.
//   Generalises the single-cycle ALU: parametrised width, multi-cycle, handshaken, back-pressurable.
// PARAMETERS
//   XLEN    32  operand/result width; 32 or 64
//   UNROLL  1   iterations per cycle; must divide XLEN (1,2,4,8)
// PORTS
//   clk           in   1     clock, rising edge
//   reset         in   1     asynchronous, active-low reset
//   req_valid     in   1     request present
//   req_ready     out  1     unit can accept; == (state==IDLE)
//   req_op        in   3     muldiv_op_t (funct3): MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   req_a         in   XLEN  rs1 operand
//   req_b         in   XLEN  rs2 operand
//   req_rd        in   5     destination tag, returned unchanged
//   resp_valid    out  1     result valid
//   resp_ready    in   1     consumer takes result
//   resp_result   out  XLEN  result
//   resp_rd       out  5     tag of this result
//   busy          out  1     state != IDLE
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, resp_valid=0, resp_result=0, resp_rd=0, busy=0; req_ready=1.
//   Reset mid-operation aborts op; no response is ever produced for it.
//   FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE: req_valid&&req_ready at edge 0 latches op, |a|,|b|, sign flags, rd; cnt=XLEN/UNROLL; -> CALC.
//   CALC: each cycle UNROLL shift-add (mul, 2*XLEN product) or restoring-divide steps; cnt--.
//     At cnt==1 edge: sign fixup + result select registered into resp_result; -> DONE.
//   DONE: resp_valid=1; resp_result/resp_rd stable until resp_valid&&resp_ready; then -> IDLE.
//   req_ready=0 outside IDLE; requests then ignored (no queueing).
//   Latency: accept edge 0 -> resp_valid high from edge XLEN/UNROLL+1 (33 cycles @32/1).
//   Result select: MUL low XLEN; MULH/MULHSU/MULHU high XLEN with s*s, s*u, u*u signedness.
//   Div by zero: DIV/DIVU -> all ones; REM/REMU -> a.
//   Signed overflow (a==MIN, b==-1): DIV -> MIN; REM -> 0.
//   REM sign follows dividend; DIV quotient negated when signs differ (nonzero divisor).
//   resp_ready high with resp_valid low: no effect. All arithmetic modulo 2^XLEN.
// CONFIGURATION
//   MULDIV_FAST_SPECIAL_EN defined: div-by-zero, signed overflow, and MUL* with a==0 or b==0
//     bypass CALC: IDLE -> DONE at accept edge; resp_valid from edge 1.
//   Undefined: special cases take full latency; results identical either way.
// STRUCTURE
//   cpu_pkg: muldiv_op_t enum (funct3 encodings), muldiv_state_t {IDLE,CALC,DONE}.
//   Sub-module muldiv_step: combinational single iteration (mul add-shift / div trial-subtract),
//     instantiated UNROLL times in a generate chain; muldiv_unit owns FSM, counter, fixup.
// TESTING (XLEN=32, UNROLL=1 unless noted)
//   MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB, resp_rd echoes tag, resp_valid exactly at edge 33.
//   MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1*2 -> 0xFFFFFFFF.
//   DIVU 100/7 -> 14, REMU -> 2; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
//   DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; with MULDIV_FAST_SPECIAL_EN latency 1.
//   resp_ready low 5 cycles in DONE -> result/rd held, req_ready 0, new req_valid ignored; then IDLE.
//   reset low at CALC cycle 10 -> IDLE, resp_valid 0, no response; UNROLL=4 run -> latency 9.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the M-extension execution unit.
// Op encodings follow funct3 of the RV32M/RV64M instructions.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the muldiv datapath.
// Mul: add-shift on {hi,lo}; div: restoring trial subtract on {rem,quo}.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   opnd,
  input  logic [2*XLEN-1:0] acc_in,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   sh;
  logic [XLEN-1:0] rem_n;
  logic            ge;

  // single mul or div iteration selected by is_div
  always_comb begin
    hi    = acc_in[2*XLEN-1:XLEN];
    lo    = acc_in[XLEN-1:0];
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    sh    = {hi, lo[XLEN-1]};
    ge    = (sh >= {1'b0, opnd});
    rem_n = sh[XLEN-1:0] - opnd;
    if (is_div)
      acc_out = {ge ? rem_n : sh[XLEN-1:0],
                 lo[XLEN-2:0], ge};
    else
      acc_out = {sum, lo[XLEN-1:1]};
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M mul/div unit, valid/ready handshake.
// MULDIV_FAST_SPECIAL_EN: div-by-zero, overflow and zero-operand mul skip CALC.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic [4:0]      resp_rd,
  output logic            busy
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int W2    = 2 * XLEN;

  muldiv_state_t   state, state_n;
  muldiv_op_t      op_in, op_q;
  logic [W2-1:0]   acc_q;
  logic [XLEN-1:0] opnd_q;
  logic            neg_a_q, neg_b_q, bz_q;
  logic [CW-1:0]   cnt_q;

  logic            fire;
  logic            sgn_a, sgn_b;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            special;
  logic [XLEN-1:0] special_res;

  logic [W2-1:0]   chain [UNROLL+1];
  logic [W2-1:0]   prod;
  logic [XLEN-1:0] quo, rem, fix_res;

  assign op_in      = muldiv_op_t'(req_op);
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);
  assign fire       = req_valid && req_ready;

  // operand signedness and magnitudes
  always_comb begin
    sgn_a = op_in inside {OP_MUL, OP_MULH, OP_MULHSU,
                          OP_DIV, OP_REM};
    sgn_b = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    neg_a = sgn_a && req_a[XLEN-1];
    neg_b = sgn_b && req_b[XLEN-1];
    abs_a = neg_a ? -req_a : req_a;
    abs_b = neg_b ? -req_b : req_b;
  end

`ifdef MULDIV_FAST_SPECIAL_EN
  // early-out detection and its result
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (op_in[2]) begin
      if (req_b == '0) begin
        special     = 1'b1;
        special_res = op_in[1] ? req_a : '1;
      end else if (!op_in[0] && req_b == '1 &&
                   req_a == {1'b1, {(XLEN-1){1'b0}}}) begin
        special     = 1'b1;
        special_res = op_in[1] ? '0 : req_a;
      end
    end else if (req_a == '0 || req_b == '0) begin
      special = 1'b1;
    end
  end
`else
  assign special     = 1'b0;
  assign special_res = '0;
`endif

  assign chain[0] = acc_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div  (op_q[2]),
      .opnd    (opnd_q),
      .acc_in  (chain[i]),
      .acc_out (chain[i+1])
    );
  end

  // sign fixup and result select on the final iteration
  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -chain[UNROLL] : chain[UNROLL];
    quo  = chain[UNROLL][XLEN-1:0];
    rem  = chain[UNROLL][W2-1:XLEN];
    unique case (op_q)
      OP_MUL:
        fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:
        fix_res = prod[W2-1:XLEN];
      OP_DIV, OP_DIVU:
        fix_res = ((neg_a_q ^ neg_b_q) && !bz_q) ? -quo : quo;
      default:
        fix_res = neg_a_q ? -rem : rem;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (fire) state_n = special ? DONE : CALC;
      CALC: if (cnt_q == CW'(1)) state_n = DONE;
      DONE: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // operand latch, iteration and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= OP_MUL;
      acc_q       <= '0;
      opnd_q      <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      bz_q        <= 1'b0;
      cnt_q       <= '0;
      resp_result <= '0;
      resp_rd     <= '0;
    end else if (fire) begin
      op_q    <= op_in;
      acc_q   <= {{XLEN{1'b0}}, abs_a};
      opnd_q  <= abs_b;
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
      bz_q    <= (req_b == '0);
      cnt_q   <= CW'(STEPS);
      resp_rd <= req_rd;
      if (special) resp_result <= special_res;
    end else if (state == CALC) begin
      acc_q <= chain[UNROLL];
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) resp_result <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (UNROLL 1 and 4).
// Special-case latency depends on MULDIV_FAST_SPECIAL_EN.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 33;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;

  logic        v1, q1rdy, rv1, rr1, busy1;
  logic [31:0] res1;
  logic [4:0]  rd1;
  logic        v4, q4rdy, rv4, rr4, busy4;
  logic [31:0] res4;
  logic [4:0]  rd4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .UNROLL(1)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (v1),
    .req_ready   (q1rdy),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rd      (req_rd),
    .resp_valid  (rv1),
    .resp_ready  (rr1),
    .resp_result (res1),
    .resp_rd     (rd1),
    .busy        (busy1)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (v4),
    .req_ready   (q4rdy),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rd      (req_rd),
    .resp_valid  (rv4),
    .resp_ready  (rr4),
    .resp_result (res4),
    .resp_rd     (rd4),
    .busy        (busy4)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input bit          u4,
                        input logic [2:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0]  rd,
                        input logic [31:0] exp,
                        input int          exp_lat,
                        input string       tag);
    int lat;
    @(negedge clk);
    check({tag, "/rdy"}, u4 ? q4rdy : q1rdy, 1);
    req_op = op;
    req_a  = a;
    req_b  = b;
    req_rd = rd;
    if (u4) v4 = 1'b1;
    else    v1 = 1'b1;
    @(posedge clk);
    #1;
    v1  = 1'b0;
    v4  = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(u4 ? rv4 : rv1) && lat < 200);
    check({tag, "/lat"}, lat, exp_lat);
    check({tag, "/res"}, u4 ? res4 : res1, exp);
    check({tag, "/rd"}, u4 ? rd4 : rd1, rd);
    if (u4) rr4 = 1'b1;
    else    rr1 = 1'b1;
    @(posedge clk);
    #1;
    rr1 = 1'b0;
    rr4 = 1'b0;
    check({tag, "/vld_off"}, u4 ? rv4 : rv1, 0);
    check({tag, "/idle"}, u4 ? q4rdy : q1rdy, 1);
  endtask

  initial begin
    int lat;
    int hits;
    reset  = 1'b0;
    v1     = 1'b0;
    v4     = 1'b0;
    rr1    = 1'b0;
    rr4    = 1'b0;
    req_op = 3'd0;
    req_a  = '0;
    req_b  = '0;
    req_rd = '0;
    #12;
    check("rst/vld", rv1, 0);
    check("rst/res", res1, 0);
    check("rst/rd", rd1, 0);
    check("rst/busy", busy1, 0);
    check("rst/rdy", q1rdy, 1);
    @(negedge clk);
    reset = 1'b1;

    run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5,
           32'hFFFF_FFEB, 33, "mul");
    run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,
           32'h4000_0000, 33, "mulh");
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
           32'hFFFF_FFFE, 33, "mulhu");
    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3,
           32'hFFFF_FFFF, 33, "mulhsu");
    run_op(0, 3'd5, 32'd100, 32'd7, 5'd4,
           32'd14, 33, "divu");
    run_op(0, 3'd7, 32'd100, 32'd7, 5'd6,
           32'd2, 33, "remu");
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7,
           32'hFFFF_FFFD, 33, "div_neg");
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8,
           32'hFFFF_FFFF, 33, "rem_neg");
    run_op(0, 3'd4, 32'd5, 32'd0, 5'd10,
           32'hFFFF_FFFF, SPL, "div0");
    run_op(0, 3'd6, 32'd5, 32'd0, 5'd11,
           32'd5, SPL, "rem0");
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd0, 5'd12,
           32'hFFFF_FFFF, SPL, "div0_neg");
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd0, 5'd13,
           32'hFFFF_FFF9, SPL, "rem0_neg");
    run_op(0, 3'd5, 32'd5, 32'd0, 5'd14,
           32'hFFFF_FFFF, SPL, "divu0");
    run_op(0, 3'd7, 32'd5, 32'd0, 5'd15,
           32'd5, SPL, "remu0");
    run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16,
           32'h8000_0000, SPL, "div_ovf");
    run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17,
           32'd0, SPL, "rem_ovf");
    run_op(0, 3'd1, 32'd0, 32'h1234_5678, 5'd18,
           32'd0, SPL, "mulh_zero");

    // back-pressure in DONE
    @(negedge clk);
    req_op = 3'd0;
    req_a  = 32'd3;
    req_b  = 32'd4;
    req_rd = 5'd9;
    v1     = 1'b1;
    @(posedge clk);
    #1;
    v1  = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rv1 && lat < 200);
    check("hold/vld", rv1, 1);
    for (int i = 0; i < 5; i++) begin
      req_op = 3'd5;
      req_a  = 32'd1;
      req_b  = 32'd1;
      req_rd = 5'd3;
      v1     = 1'b1;
      @(negedge clk);
      check("hold/res", res1, 32'd12);
      check("hold/rd", rd1, 5'd9);
      check("hold/rdy", q1rdy, 0);
    end
    v1  = 1'b0;
    rr1 = 1'b1;
    @(posedge clk);
    #1;
    rr1 = 1'b0;
    check("hold/busy", busy1, 0);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rv1) hits++;
    end
    check("hold/no_queue", hits, 0);

    // reset in the middle of CALC
    @(negedge clk);
    req_op = 3'd5;
    req_a  = 32'd100;
    req_b  = 32'd7;
    req_rd = 5'd21;
    v1     = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    repeat (10) @(negedge clk);
    check("abort/busy_pre", busy1, 1);
    reset = 1'b0;
    #1;
    check("abort/busy", busy1, 0);
    check("abort/vld", rv1, 0);
    check("abort/rdy", q1rdy, 1);
    check("abort/res", res1, 0);
    @(negedge clk);
    reset = 1'b1;
    hits  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rv1) hits++;
    end
    check("abort/no_resp", hits, 0);

    // UNROLL=4 instance
    run_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd22,
           32'hFFFF_FFEB, 9, "u4_mul");
    run_op(1, 3'd5, 32'd100, 32'd7, 5'd23,
           32'd14, 9, "u4_divu");
    run_op(1, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd24,
           32'hFFFF_FFFF, 9, "u4_rem");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
